// File: rtl/ultrasonic_scheduler.sv
// Round-robin scheduler sharing one pulse-width measurement path between
// several ultrasonic rangefinders: trigger, route echo, wait, latch result.
module ultrasonic_scheduler #(
    parameter int N_SENSORS      = 3,
    parameter int TRIG_CYCLES    = 200,
    parameter int TIMEOUT_CYCLES = 500_000,
    parameter int SETTLE_CYCLES  = 4,
    parameter int GAP_CYCLES     = 10_000,
    localparam int DATA_W        = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [N_SENSORS-1:0]        pw_in,
    input  logic [DATA_W-1:0]           meas_distance,
    output logic [N_SENSORS-1:0]        trig,
    output logic                        pwm_sel,
    output logic [DATA_W*N_SENSORS-1:0] dist_out,
    output logic                        dist_valid,
    output logic [2:0]                  dist_idx,
    output logic [N_SENSORS-1:0]        timeout_err
);

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int CNT_MAX = max_of(max_of(TRIG_CYCLES, TIMEOUT_CYCLES),
                                    max_of(SETTLE_CYCLES, GAP_CYCLES));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // A timed-out slot reports full-scale distance so downstream logic sees "nothing in range".
    function automatic logic [DATA_W-1:0] result_byte(input logic timed_out_f,
                                                      input logic [DATA_W-1:0] meas);
        return timed_out_f ? {DATA_W{1'b1}} : meas;
    endfunction

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        WAIT_FALL,
        SETTLE,
        LATCH,
        GAP
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [CNT_W-1:0]     tcnt, tcnt_nxt;
    logic [2:0]           cur, cur_nxt;
    logic                 timed_out, timed_out_nxt;
    logic [N_SENSORS-1:0] cur_hot;
    logic                 pw_cur;
    logic                 latch_en;

    always_comb begin
        cur_hot = '0;
        for (int i = 0; i < N_SENSORS; i++) begin
            cur_hot[i] = (cur == 3'(i));
        end
        pw_cur = |(pw_in & cur_hot);
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        tcnt_nxt      = tcnt;
        cur_nxt       = cur;
        timed_out_nxt = timed_out;
        latch_en      = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = TRIG;
                    cnt_nxt   = CNT_W'(TRIG_CYCLES - 1);
                end
            end
            TRIG: begin
                if (cnt == '0) begin
                    state_nxt     = WAIT_RISE;
                    tcnt_nxt      = '0;
                    timed_out_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            WAIT_RISE: begin
                // Timeout has priority so a slot never exceeds its budget.
                if (tcnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt     = LATCH;
                    timed_out_nxt = 1'b1;
                end else begin
                    tcnt_nxt = tcnt + CNT_W'(1);
                    if (pw_cur) state_nxt = WAIT_FALL;
                end
            end
            WAIT_FALL: begin
                if (tcnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt     = LATCH;
                    timed_out_nxt = 1'b1;
                end else begin
                    tcnt_nxt = tcnt + CNT_W'(1);
                    if (!pw_cur) begin
                        state_nxt = SETTLE;
                        cnt_nxt   = CNT_W'(SETTLE_CYCLES - 1);
                    end
                end
            end
            SETTLE: begin
                if (cnt == '0) state_nxt = LATCH;
                else           cnt_nxt   = cnt - CNT_W'(1);
            end
            LATCH: begin
                latch_en  = 1'b1;
                cur_nxt   = (cur == 3'(N_SENSORS - 1)) ? 3'd0 : cur + 3'd1;
                state_nxt = GAP;
                cnt_nxt   = CNT_W'(GAP_CYCLES - 1);
            end
            GAP: begin
                if (cnt == '0) begin
                    if (enable) begin
                        state_nxt = TRIG;
                        cnt_nxt   = CNT_W'(TRIG_CYCLES - 1);
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            tcnt      <= '0;
            cur       <= 3'd0;
            timed_out <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            tcnt      <= tcnt_nxt;
            cur       <= cur_nxt;
            timed_out <= timed_out_nxt;
        end
    end

    // Outputs are registered from the current state, so they trail the state by one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trig        <= '0;
            pwm_sel     <= 1'b0;
            dist_out    <= '0;
            dist_valid  <= 1'b0;
            dist_idx    <= 3'd0;
            timeout_err <= '0;
        end else begin
            trig       <= (state == TRIG) ? cur_hot : '0;
            pwm_sel    <= (state == WAIT_RISE || state == WAIT_FALL) ? pw_cur : 1'b0;
            dist_valid <= latch_en;
            if (latch_en) begin
                dist_idx <= cur;
                for (int i = 0; i < N_SENSORS; i++) begin
                    if (cur_hot[i]) begin
                        dist_out[DATA_W*i +: DATA_W] <= result_byte(timed_out, meas_distance);
                        timeout_err[i]               <= timed_out;
                    end
                end
            end
        end
    end

endmodule
